div_float_sequencer: RTL and testbench

- IEEE-754 single-precision divider, out = a / b, built as the initiator side of the reciprocal core's start/done handshake.
- Handles special operands locally.
- Otherwise sends |b| to an external reciprocal_float instance, waits for its done, then multiplies a by the returned reciprocal with round-to-nearest-even.
- Sits between the datapath control FSM and one shared reciprocal core.

---
 rtl/div_float_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_div_float_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_float_sequencer.sv
// IEEE-754 single-precision divider: out = a / b via an external reciprocal core plus an RNE multiply.
// Special operands are resolved locally without ever starting the core.
module div_float_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        done,
    output logic        zero_flag,
    output logic        err,
    output logic        busy,
    output logic        rcp_start,
    output logic [31:0] rcp_x,
    input  logic [31:0] rcp_out,
    input  logic        rcp_done,
    input  logic        rcp_zero
);
    localparam int unsigned W  = 32;
    localparam int unsigned MW = 24;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned EW = 10;
    localparam int unsigned CW = 16;
    localparam logic [W-1:0]  QNAN     = 32'h7FC0_0000;
    localparam logic [W-2:0]  INF_MAG  = 31'h7F80_0000;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, RCP_REQ, RCP_WAIT, MUL, NORM, DONE
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]         a_q, b_q, r_q;
    logic [PW-1:0]        prod_q;
    logic signed [EW-1:0] e_q;
    logic [CW-1:0]        cnt_q;

    logic [W-1:0] out_nxt, rcp_x_nxt;
    logic         zero_nxt, err_nxt;

    function automatic logic [W-1:0] ftz(input logic [W-1:0] x);
        ftz = (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
    endfunction

    // Operand classification on the latched (already flushed) operands
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign ma     = a_q[22:0];
    assign mb     = b_q[22:0];
    assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign sgn    = a_q[31] ^ b_q[31];

    logic         special;
    logic [W-1:0] spec_out;
    logic         spec_zero;

    always_comb begin
        special   = 1'b1;
        spec_out  = QNAN;
        spec_zero = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_out = QNAN;
        end else if (b_zero) begin
            spec_out  = {sgn, INF_MAG};
            spec_zero = 1'b1;
        end else if (a_inf) begin
            spec_out = {sgn, INF_MAG};
        end else if (b_inf || a_zero) begin
            spec_out = {sgn, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Normalise, round to nearest even, then clamp to inf or zero
    logic signed [EW-1:0] e_n;
    logic [22:0]          mant;
    logic                 grd, stk;
    logic [MW-1:0]        mant_r;
    logic [W-1:0]         norm_out;
    logic                 s_n;

    always_comb begin
        s_n = sgn ^ r_q[31];
        if (prod_q[PW-1]) begin
            mant = prod_q[46:24];
            grd  = prod_q[23];
            stk  = |prod_q[22:0];
            e_n  = e_q + 10'sd1;
        end else begin
            mant = prod_q[45:23];
            grd  = prod_q[22];
            stk  = |prod_q[21:0];
            e_n  = e_q;
        end
        mant_r = {1'b0, mant} + MW'(grd & (stk | mant[0]));
        if (mant_r[MW-1]) begin
            e_n = e_n + 10'sd1;
        end
        if (e_n >= 10'sd255) begin
            norm_out = {s_n, INF_MAG};
        end else if (e_n <= 10'sd0) begin
            norm_out = {s_n, 31'd0};
        end else begin
            norm_out = {s_n, e_n[7:0], mant_r[22:0]};
        end
    end

    logic timeout_hit;
    assign timeout_hit = (cnt_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = CLASSIFY;
            CLASSIFY: state_nxt = special ? DONE : RCP_REQ;
            RCP_REQ:  state_nxt = RCP_WAIT;
            RCP_WAIT: begin
                if (rcp_done) begin
                    state_nxt = MUL;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            MUL:      state_nxt = NORM;
            NORM:     state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered result and core operand
    always_comb begin
        out_nxt   = out;
        zero_nxt  = zero_flag;
        err_nxt   = err;
        rcp_x_nxt = rcp_x;
        unique case (state)
            IDLE: begin
                if (start) begin
                    out_nxt  = '0;
                    zero_nxt = 1'b0;
                    err_nxt  = 1'b0;
                end
            end
            CLASSIFY: begin
                if (special) begin
                    out_nxt  = spec_out;
                    zero_nxt = spec_zero;
                end else begin
                    rcp_x_nxt = {1'b0, b_q[30:0]};
                end
            end
            RCP_WAIT: begin
                if (rcp_done) begin
                    zero_nxt = zero_flag | rcp_zero;
                end else if (timeout_hit) begin
                    out_nxt = QNAN;
                    err_nxt = 1'b1;
                end
            end
            NORM:    out_nxt = norm_out;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            done      <= 1'b0;
            zero_flag <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rcp_start <= 1'b0;
            rcp_x     <= '0;
        end else begin
            out       <= out_nxt;
            done      <= (state_nxt == DONE);
            zero_flag <= zero_nxt;
            err       <= err_nxt;
            busy      <= (state_nxt != IDLE);
            rcp_start <= (state_nxt == RCP_REQ);
            rcp_x     <= rcp_x_nxt;
        end
    end

    // Operand, reciprocal and multiplier datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            prod_q <= '0;
            e_q    <= '0;
            cnt_q  <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_q <= ftz(a);
                b_q <= ftz(b);
            end
            if (state == RCP_REQ) begin
                cnt_q <= '0;
            end else if (state == RCP_WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (state == RCP_WAIT && rcp_done) begin
                r_q <= rcp_out;
            end
            if (state == MUL) begin
                prod_q <= PW'({1'b1, a_q[22:0]}) * PW'({1'b1, r_q[22:0]});
                e_q    <= $signed({2'b00, a_q[30:23]}) + $signed({2'b00, r_q[30:23]}) - 10'sd127;
            end
        end
    end

endmodule

// File: tb/tb_div_float_sequencer.sv
// Self-checking bench for div_float_sequencer: directed vector table, corner sequences,
// and randomized operands against an arithmetic reference model with a mock reciprocal core.
module tb_div_float_sequencer;
    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst, start, done, zero_flag, err, busy, rcp_start, rcp_done, rcp_zero;
    logic [31:0] a, b, out, rcp_x, rcp_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_float_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .out(out), .done(done), .zero_flag(zero_flag), .err(err), .busy(busy),
        .rcp_start(rcp_start), .rcp_x(rcp_x), .rcp_out(rcp_out),
        .rcp_done(rcp_done), .rcp_zero(rcp_zero)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] flush(input logic [31:0] x);
        return (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
    endfunction

    // Reference special-operand handling, in priority order
    function automatic bit model_special(input logic [31:0] av, input logic [31:0] bv,
                                         output logic [31:0] o, output bit z);
        logic [31:0] fa, fb;
        bit an, bn, ai, bi, az, bz;
        logic s;
        fa = flush(av);
        fb = flush(bv);
        an = (fa[30:23] == 8'hFF) && (fa[22:0] != 0);
        bn = (fb[30:23] == 8'hFF) && (fb[22:0] != 0);
        ai = (fa[30:23] == 8'hFF) && (fa[22:0] == 0);
        bi = (fb[30:23] == 8'hFF) && (fb[22:0] == 0);
        az = (fa[30:0] == 0);
        bz = (fb[30:0] == 0);
        s  = av[31] ^ bv[31];
        z  = 1'b0;
        o  = 32'd0;
        if (an || bn || (az && bz) || (ai && bi)) begin o = 32'h7FC00000; return 1'b1; end
        if (bz) begin o = {s, 31'h7F800000}; z = 1'b1; return 1'b1; end
        if (ai) begin o = {s, 31'h7F800000}; return 1'b1; end
        if (bi || az) begin o = {s, 31'd0}; return 1'b1; end
        return 1'b0;
    endfunction

    // Reference a * r with integer mantissa arithmetic and round-half-to-even
    function automatic logic [31:0] model_mul(input logic [31:0] av, input logic [31:0] rv, input logic s);
        longint unsigned ma, mr, p, q, rem, half;
        int e, sh;
        ma = 64'({1'b1, av[22:0]});
        mr = 64'({1'b1, rv[22:0]});
        e  = int'(av[30:23]) + int'(rv[30:23]) - 127;
        p  = ma * mr;
        if (p >= (64'd1 << 47)) begin sh = 24; e++; end
        else sh = 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
        if (e >= 255) return {s, 31'h7F800000};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), 23'(q)};
    endfunction

    function automatic logic [31:0] rand_norm(input bit allow_neg);
        logic sg;
        sg = allow_neg ? 1'($urandom) : 1'b0;
        return {sg, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    // One request with a mock core answering dly cycles after rcp_start, done held for hold cycles
    task automatic run_check(input string nm, input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] rv, input int dly, input int hold,
                             input bit respond, input bit inject,
                             input logic [31:0] x_out, input bit x_zero, input bit x_err,
                             input bit x_special);
        int cyc, start_cyc, rd_cyc, done_cyc, nstart, hold_left, extra, exp_done;
        bit held;
        logic [31:0] rcpx, o_out;
        logic o_zero, o_err;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        check({nm, "/clr_out"}, out, 32'd0);
        check({nm, "/clr_flags"}, {29'd0, zero_flag, err, busy}, 32'd1);
        cyc = 1; start_cyc = -1; rd_cyc = -1; done_cyc = -1; nstart = 0; hold_left = 0;
        rcpx = 32'd0; o_out = 32'd0; o_zero = 1'b0; o_err = 1'b0;
        while (done_cyc < 0 && cyc < 3 * TMO) begin
            if (rcp_start) begin
                nstart++;
                if (start_cyc < 0) begin start_cyc = cyc; rcpx = rcp_x; end
            end
            if (done) begin done_cyc = cyc; o_out = out; o_zero = zero_flag; o_err = err; end
            if (respond && start_cyc >= 0 && rd_cyc < 0 && cyc == start_cyc + dly) begin
                rcp_done = 1'b1; rcp_out = rv; rd_cyc = cyc; hold_left = hold - 1;
            end else if (hold_left > 0) begin
                rcp_done = 1'b1; hold_left--;
            end else begin
                rcp_done = 1'b0; rcp_out = $urandom;
            end
            start = (inject && cyc == 6);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s/no_done: got no done within %0d cycles, required a done pulse", nm, cyc);
            rcp_done = 1'b0;
            return;
        end
        extra = 0; held = 1'b1;
        repeat (6) begin
            if (done) extra++;
            if (out !== o_out || busy) held = 1'b0;
            if (hold_left > 0) begin rcp_done = 1'b1; hold_left--; end
            else rcp_done = 1'b0;
            @(negedge clk);
        end
        exp_done = x_special ? 2 : (respond ? rd_cyc + 3 : 3 + int'(TMO));
        check({nm, "/done_cyc"}, 32'(done_cyc), 32'(exp_done));
        check({nm, "/out"}, o_out, x_out);
        check({nm, "/zero_err"}, {30'd0, o_zero, o_err}, {30'd0, x_zero, x_err});
        check({nm, "/n_rcp_start"}, 32'(nstart), x_special ? 32'd0 : 32'd1);
        if (!x_special) begin
            check({nm, "/rcp_start_cyc"}, 32'(start_cyc), 32'd2);
            check({nm, "/rcp_x"}, rcpx, {1'b0, bv[30:0]});
        end
        check({nm, "/extra_done"}, 32'(extra), 32'd0);
        check({nm, "/hold"}, 32'(held), 32'd1);
    endtask

    typedef struct {
        logic [31:0] a, b, r;
        int          dly;
        logic [31:0] x_out;
        bit          x_zero, x_err, x_special;
    } vec_t;

    vec_t vt[15];
    logic [31:0] pool[8];

    initial begin
        int late;
        vt[0]  = '{32'h40C00000, 32'h40400000, 32'h3EAAAAAB, 20, 32'h40000000, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{32'h3F800000, 32'hC44B1AF7, 32'h3AA155C3, 7,  32'hBAA155C3, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h3F800000, 32'h00000000, 32'h0,        1,  32'h7F800000, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{32'h3F800000, 32'h80000001, 32'h0,        1,  32'hFF800000, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{32'h00000000, 32'h00000000, 32'h0,        1,  32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{32'h3F800000, 32'h7F800000, 32'h0,        1,  32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'h7F000000, 32'h3E800000, 32'h40800000, 5,  32'h7F800000, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{32'h7FC00001, 32'h3F800000, 32'h0,        1,  32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{32'h7F800000, 32'h7F800000, 32'h0,        1,  32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{32'h7F800000, 32'hC0000000, 32'h0,        1,  32'hFF800000, 1'b0, 1'b0, 1'b1};
        vt[10] = '{32'h80000000, 32'h3F800000, 32'h0,        1,  32'h80000000, 1'b0, 1'b0, 1'b1};
        vt[11] = '{32'h00800000, 32'h3F800000, 32'h3F000000, 3,  32'h00000000, 1'b0, 1'b0, 1'b0};
        vt[12] = '{32'h3FFFFFFF, 32'h3F000000, 32'h3F800001, 2,  32'h40000000, 1'b0, 1'b0, 1'b0};
        vt[13] = '{32'h00000000, 32'h7FC00000, 32'h0,        1,  32'h7FC00000, 1'b0, 1'b0, 1'b1};
        vt[14] = '{32'h3F800001, 32'h3F800000, 32'h3FC00000, 1,  32'h3FC00002, 1'b0, 1'b0, 1'b0};
        pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'h00000001, 32'h80400000, 32'h7F800001};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        rcp_done = 1'b0; rcp_out = '0; rcp_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/out", out, 32'd0);
        check("reset/flags", {27'd0, done, zero_flag, err, busy, rcp_start}, 32'd0);
        check("reset/rcp_x", rcp_x, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle/flags", {27'd0, done, zero_flag, err, busy, rcp_start}, 32'd0);

        foreach (vt[i])
            run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].r, vt[i].dly, 1, 1'b1, 1'b0,
                      vt[i].x_out, vt[i].x_zero, vt[i].x_err, vt[i].x_special);

        run_check("timeout", 32'h40C00000, 32'h40400000, 32'h0, 1, 1, 1'b0, 1'b0,
                  32'h7FC00000, 1'b0, 1'b1, 1'b0);
        run_check("after_tmo", 32'h40C00000, 32'h40400000, 32'h3EAAAAAB, 20, 1, 1'b1, 1'b0,
                  32'h40000000, 1'b0, 1'b0, 1'b0);
        run_check("inject_level", 32'h3F800000, 32'hC44B1AF7, 32'h3AA155C3, 20, 5, 1'b1, 1'b1,
                  32'hBAA155C3, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation, then a stale core done that must be ignored
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid/pre", {30'd0, busy, rcp_start}, 32'd2);
        check("rstmid/pre_rcp_x", rcp_x, 32'h40400000);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid/flags", {27'd0, done, zero_flag, err, busy, rcp_start}, 32'd0);
        check("rstmid/out", out, 32'd0);
        check("rstmid/rcp_x", rcp_x, 32'd0);
        rst = 1'b0; rcp_done = 1'b1; rcp_out = 32'h3F800000;
        late = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) rcp_done = 1'b0;
            if (done || busy) late++;
        end
        check("rstmid/late_done", 32'(late), 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] av, bv, rv, xo;
            bit xz, xs;
            av = ($urandom % 6 == 0) ? pool[$urandom % 8] : rand_norm(1'b1);
            bv = ($urandom % 6 == 0) ? pool[$urandom % 8] : rand_norm(1'b1);
            rv = rand_norm(1'b0);
            xs = model_special(av, bv, xo, xz);
            if (!xs) xo = model_mul(flush(av), rv, av[31] ^ bv[31]);
            run_check($sformatf("rnd%0d", i), av, bv, rv, 1 + int'($urandom % 40),
                      1 + int'($urandom % 4), 1'b1, 1'b0, xo, xz, 1'b0, xs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
